// File: rtl/aes_pkg.sv
// Shared AES streaming types: block width and scheduler states.
// Imported by the stream controller.
package aes_pkg;

  localparam int BLOCK_WIDTH = 128;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    RUN,
    PUSH
  } aes_stream_state_e;

endpackage

// File: rtl/aes_stream_ctrl.sv
// Single-block scheduler: input FIFO -> AES core -> output FIFO.
// Ports: clk/rst (sync, active-high), enable_i, in FIFO pop/data,
//   core start/block/done/result, out FIFO push/data, busy_o,
//   block_cnt_o (completed blocks), timeout_o (sticky watchdog).
// Macro AES_STREAM_CTRL_TIMEOUT_EN enables the RUN watchdog.
module aes_stream_ctrl
  import aes_pkg::*;
#(
  parameter int DATA_WIDTH     = BLOCK_WIDTH,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic                  in_empty_i,
  output logic                  in_pop_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  core_start_o,
  output logic [DATA_WIDTH-1:0] core_block_o,
  input  logic                  core_done_i,
  input  logic [DATA_WIDTH-1:0] core_result_i,
  input  logic                  out_full_i,
  output logic                  out_push_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  block_cnt_o,
  output logic                  timeout_o
);

  aes_stream_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] block_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  can_pop;
  logic                  wd_expire;

  assign can_pop = enable_i & ~in_empty_i;

`ifdef AES_STREAM_CTRL_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDW-1:0] wd_q;
  logic           timeout_q;

  // Done arriving on the last allowed cycle still wins.
  assign wd_expire = (state_q == RUN) && !core_done_i &&
                     (wd_q == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == START)
        wd_q <= '0;
      else if (state_q == RUN)
        wd_q <= wd_q + 1'b1;
      if (wd_expire)
        timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_wd;
  assign unused_wd = ^TIMEOUT_CYCLES;
  assign wd_expire = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      block_q  <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == LOAD)
        block_q <= in_data_i;
      if (state_q == RUN && core_done_i)
        result_q <= core_result_i;
      if (state_q == PUSH && !out_full_i)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    in_pop_o     = 1'b0;
    core_start_o = 1'b0;
    out_push_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (can_pop)
          state_d = POP;
      end
      POP: begin
        in_pop_o = 1'b1;
        state_d  = LOAD;
      end
      LOAD: begin
        state_d = START;
      end
      START: begin
        core_start_o = 1'b1;
        state_d      = RUN;
      end
      RUN: begin
        if (core_done_i)
          state_d = PUSH;
        else if (wd_expire)
          state_d = IDLE;
      end
      PUSH: begin
        out_push_o = ~out_full_i;
        if (!out_full_i)
          state_d = can_pop ? POP : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign core_block_o = block_q;
  assign out_data_o   = result_q;
  assign busy_o       = (state_q != IDLE);
  assign block_cnt_o  = cnt_q;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Directed bench for aes_stream_ctrl with FIFO models
// and a stub core returning ~block ten cycles after start.
module tb_aes_stream_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable_i;
  logic         in_empty_i;
  logic         in_pop_o;
  logic [127:0] in_data_i;
  logic         core_start_o;
  logic [127:0] core_block_o;
  logic         core_done_i;
  logic [127:0] core_result_i;
  logic         out_full_i;
  logic         out_push_o;
  logic [127:0] out_data_o;
  logic         busy_o;
  logic [15:0]  block_cnt_o;
  logic         timeout_o;

  aes_stream_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
    .in_empty_i   (in_empty_i),
    .in_pop_o     (in_pop_o),
    .in_data_i    (in_data_i),
    .core_start_o (core_start_o),
    .core_block_o (core_block_o),
    .core_done_i  (core_done_i),
    .core_result_i(core_result_i),
    .out_full_i   (out_full_i),
    .out_push_o   (out_push_o),
    .out_data_o   (out_data_o),
    .busy_o       (busy_o),
    .block_cnt_o  (block_cnt_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  logic [127:0] in_q[$];
  logic [127:0] out_q[$];
  int pop_n = 0;
  int start_n = 0;
  int push_n = 0;
  int p0, s0, u0;
  int total = 0;
  int bad = 0;

  assign in_empty_i = (in_q.size() == 0);

  always @(posedge clk) begin
    if (in_pop_o && in_q.size() > 0)
      in_data_i <= in_q.pop_front();
    if (in_pop_o) pop_n++;
    if (core_start_o) start_n++;
    if (out_push_o) begin
      push_n++;
      out_q.push_back(out_data_o);
    end
  end

  logic [127:0] stub_blk = '0;
  int           stub_cnt = 0;
  logic         stub_done = 1'b0;
  logic         stub_mute = 1'b0;
  logic         spur = 1'b0;

  always @(posedge clk) begin
    if (core_start_o) begin
      stub_blk <= core_block_o;
      stub_cnt <= 10;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
    end
    stub_done <= (stub_cnt == 1) && !core_start_o && !stub_mute;
  end

  assign core_done_i   = stub_done | spur;
  assign core_result_i = ~stub_blk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    in_q.delete();
    out_q.delete();
    p0 = pop_n;
    s0 = start_n;
    u0 = push_n;
  endtask

  task automatic expire(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic test_reset();
    enable_i = 1'b0;
    out_full_i = 1'b0;
    rst = 1'b1;
    tick(2);
    total++;
    if ({in_pop_o, core_start_o, out_push_o, busy_o} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 0000",
               {in_pop_o, core_start_o, out_push_o, busy_o});
    end
    total++;
    if (block_cnt_o !== 16'd0) begin
      bad++;
      $display("FAIL reset_cnt: got %0d want 0", block_cnt_o);
    end
    total++;
    if (out_data_o !== '0 || core_block_o !== '0) begin
      bad++;
      $display("FAIL reset_data: out %h blk %h want 0", out_data_o, core_block_o);
    end
    total++;
    if (timeout_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_to: got %b want 0", timeout_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [127:0] d;
    int g;
    d = 128'h00112233445566778899aabbccddeeff;
    do_reset();
    in_q.push_back(d);
    enable_i = 1'b1;
    g = 0;
    while (!in_pop_o && g < 20) begin tick(1); g++; end
    if (g >= 20) expire("single_pop");
    tick(2);
    total++;
    if (core_start_o !== 1'b1 || core_block_o !== d) begin
      bad++;
      $display("FAIL single_start: start %b blk %h want 1 %h",
               core_start_o, core_block_o, d);
    end
    g = 0;
    while (!out_push_o && g < 40) begin tick(1); g++; end
    if (g >= 40) expire("single_push");
    total++;
    if (out_data_o !== 128'hffeeddccbbaa99887766554433221100) begin
      bad++;
      $display("FAIL single_data: got %h want ffeeddccbbaa99887766554433221100",
               out_data_o);
    end
    tick(1);
    total++;
    if (block_cnt_o !== 16'd1 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL single_end: cnt %0d busy %b want 1 0", block_cnt_o, busy_o);
    end
    total++;
    if (pop_n - p0 != 1 || start_n - s0 != 1 || push_n - u0 != 1) begin
      bad++;
      $display("FAIL single_counts: pop %0d start %0d push %0d want 1 1 1",
               pop_n - p0, start_n - s0, push_n - u0);
    end
    enable_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [127:0] b[4];
    int g;
    int idle_n;
    bit started;
    b[0] = 128'h0123456789abcdef_fedcba9876543210;
    b[1] = 128'h11111111_22222222_33333333_44444444;
    b[2] = 128'hdeadbeef_cafef00d_00000000_ffffffff;
    b[3] = 128'h80000000_00000000_00000000_00000001;
    do_reset();
    for (int i = 0; i < 4; i++) in_q.push_back(b[i]);
    enable_i = 1'b1;
    g = 0;
    idle_n = 0;
    started = 1'b0;
    while (push_n - u0 < 4 && g < 200) begin
      tick(1);
      g++;
      if (push_n - u0 >= 4) break;
      if (busy_o) started = 1'b1;
      else if (started) idle_n++;
    end
    if (g >= 200) expire("stream_wait");
    total++;
    if (idle_n != 0) begin
      bad++;
      $display("FAIL stream_chain: idle cycles %0d want 0", idle_n);
    end
    total++;
    if (pop_n - p0 != 4 || start_n - s0 != 4) begin
      bad++;
      $display("FAIL stream_counts: pop %0d start %0d want 4 4",
               pop_n - p0, start_n - s0);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_q.size() <= i || out_q[i] !== ~b[i]) begin
        bad++;
        $display("FAIL stream_data%0d: got %h want %h", i,
                 out_q.size() > i ? out_q[i] : 128'hx, ~b[i]);
      end
    end
    tick(1);
    total++;
    if (block_cnt_o !== 16'd4 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL stream_end: cnt %0d busy %b want 4 0", block_cnt_o, busy_o);
    end
    enable_i = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [127:0] b1, b2;
    int g;
    int err;
    b1 = 128'h0f0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f0f;
    b2 = 128'h12345678_9abcdef0_12345678_9abcdef0;
    do_reset();
    out_full_i = 1'b1;
    in_q.push_back(b1);
    in_q.push_back(b2);
    enable_i = 1'b1;
    g = 0;
    while (!core_done_i && g < 40) begin tick(1); g++; end
    if (g >= 40) expire("bp_done");
    tick(1);
    err = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_push_o !== 1'b0 || out_data_o !== ~b1 || busy_o !== 1'b1) err++;
      tick(1);
    end
    total++;
    if (err != 0) begin
      bad++;
      $display("FAIL bp_hold: %0d bad cycles want 0", err);
    end
    total++;
    if (pop_n - p0 != 1 || push_n - u0 != 0) begin
      bad++;
      $display("FAIL bp_counts: pop %0d push %0d want 1 0",
               pop_n - p0, push_n - u0);
    end
    out_full_i = 1'b0;
    #1;
    total++;
    if (out_push_o !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: push %b want 1", out_push_o);
    end
    tick(1);
    total++;
    if (push_n - u0 != 1 || in_pop_o !== 1'b1) begin
      bad++;
      $display("FAIL bp_chain: push %0d pop %b want 1 1", push_n - u0, in_pop_o);
    end
    g = 0;
    while (push_n - u0 < 2 && g < 40) begin tick(1); g++; end
    if (g >= 40) expire("bp_second");
    total++;
    if (out_q.size() != 2 || out_q[1] !== ~b2 || block_cnt_o !== 16'd2) begin
      bad++;
      $display("FAIL bp_second: n %0d cnt %0d want 2 2", out_q.size(), block_cnt_o);
    end
    enable_i = 1'b0;
    tick(2);
  endtask

  task automatic test_disable();
    logic [127:0] b1, b2;
    int g;
    b1 = 128'haaaaaaaa_55555555_aaaaaaaa_55555555;
    b2 = 128'h00000000_00000000_00000000_0000abcd;
    do_reset();
    enable_i = 1'b0;
    in_q.push_back(b1);
    tick(50);
    total++;
    if (pop_n - p0 != 0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL dis_nopop: pop %0d busy %b want 0 0", pop_n - p0, busy_o);
    end
    spur = 1'b1;
    tick(1);
    spur = 1'b0;
    tick(2);
    total++;
    if (busy_o !== 1'b0 || out_data_o !== '0 || push_n - u0 != 0) begin
      bad++;
      $display("FAIL dis_spur: busy %b data %h push %0d want 0 0 0",
               busy_o, out_data_o, push_n - u0);
    end
    in_q.push_back(b2);
    enable_i = 1'b1;
    g = 0;
    while (!core_start_o && g < 20) begin tick(1); g++; end
    if (g >= 20) expire("dis_start");
    tick(2);
    enable_i = 1'b0;
    g = 0;
    while (push_n - u0 < 1 && g < 40) begin tick(1); g++; end
    if (g >= 40) expire("dis_push");
    total++;
    if (out_q.size() < 1 || out_q[0] !== ~b1) begin
      bad++;
      $display("FAIL dis_data: got %h want %h",
               out_q.size() > 0 ? out_q[0] : 128'hx, ~b1);
    end
    tick(10);
    total++;
    if (busy_o !== 1'b0 || pop_n - p0 != 1 || block_cnt_o !== 16'd1) begin
      bad++;
      $display("FAIL dis_end: busy %b pop %0d cnt %0d want 0 1 1",
               busy_o, pop_n - p0, block_cnt_o);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] b1, b2;
    int g;
    b1 = 128'h13579bdf_2468ace0_13579bdf_2468ace0;
    b2 = 128'hfedcba98_76543210_00000000_11111111;
    do_reset();
    in_q.push_back(b1);
    enable_i = 1'b1;
    g = 0;
    while (!core_start_o && g < 20) begin tick(1); g++; end
    if (g >= 20) expire("rmr_start");
    tick(3);
    rst = 1'b1;
    tick(1);
    total++;
    if ({in_pop_o, core_start_o, out_push_o, busy_o} !== 4'b0 ||
        block_cnt_o !== 16'd0 || core_block_o !== '0 || out_data_o !== '0) begin
      bad++;
      $display("FAIL rmr_zero: ctl %b cnt %0d want 0000 0",
               {in_pop_o, core_start_o, out_push_o, busy_o}, block_cnt_o);
    end
    rst = 1'b0;
    tick(15);
    total++;
    if (push_n - u0 != 0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL rmr_late: push %0d busy %b want 0 0", push_n - u0, busy_o);
    end
    in_q.push_back(b2);
    g = 0;
    while (push_n - u0 < 1 && g < 40) begin tick(1); g++; end
    if (g >= 40) expire("rmr_next");
    tick(1);
    total++;
    if (out_q.size() != 1 || out_q[0] !== ~b2 || block_cnt_o !== 16'd1) begin
      bad++;
      $display("FAIL rmr_next: n %0d cnt %0d want 1 1", out_q.size(), block_cnt_o);
    end
    enable_i = 1'b0;
  endtask

  task automatic test_timeout();
    int g;
    do_reset();
    stub_mute = 1'b1;
    in_q.push_back(128'h5a5a5a5a_5a5a5a5a_5a5a5a5a_5a5a5a5a);
    enable_i = 1'b1;
    g = 0;
    while (!core_start_o && g < 20) begin tick(1); g++; end
    if (g >= 20) expire("to_start");
    enable_i = 1'b0;
    tick(1);
`ifdef AES_STREAM_CTRL_TIMEOUT_EN
    tick(63);
    total++;
    if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL to_early: to %b busy %b want 0 1", timeout_o, busy_o);
    end
    tick(1);
    total++;
    if (timeout_o !== 1'b1 || busy_o !== 1'b0 || block_cnt_o !== 16'd0) begin
      bad++;
      $display("FAIL to_fire: to %b busy %b cnt %0d want 1 0 0",
               timeout_o, busy_o, block_cnt_o);
    end
    tick(5);
    total++;
    if (timeout_o !== 1'b1 || push_n - u0 != 0) begin
      bad++;
      $display("FAIL to_sticky: to %b push %0d want 1 0", timeout_o, push_n - u0);
    end
`else
    tick(100);
    total++;
    if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL to_none: to %b busy %b want 0 1", timeout_o, busy_o);
    end
`endif
    stub_mute = 1'b0;
    do_reset();
  endtask

  initial begin
    rst = 1'b1;
    enable_i = 1'b0;
    out_full_i = 1'b0;
    in_data_i = '0;
    tick(1);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_disable();
    test_reset_mid_run();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_stream_ctrl.md
Name: aes_stream_ctrl

Overview:
- Single-block scheduler between the 128-bit input FIFO, the AES core and the 128-bit output FIFO.
- Pops one block from the input FIFO and launches it on the core with a one-cycle start pulse.
- Captures the core result and pushes it into the output FIFO, honouring full/empty flags.
- Processes one block at a time; counts completed blocks for status/CSR readback.

Parameters:
- DATA_WIDTH, 128, block width (input FIFO, core, output FIFO)
- CNT_WIDTH, 16, width of completed-block counter
- TIMEOUT_CYCLES, 64, watchdog limit on core_done_i wait (used only with AES_STREAM_CTRL_TIMEOUT_EN)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable_i  in  1  allow new blocks to start
- in_empty_i  in  1  input FIFO empty flag
- in_pop_o  out  1  input FIFO pop request
- in_data_i  in  DATA_WIDTH  input FIFO read data, valid the cycle after in_pop_o
- core_start_o  out  1  one-cycle launch pulse to AES core
- core_block_o  out  DATA_WIDTH  block to core, stable from START until the result is captured
- core_done_i  in  1  core result valid (one-cycle pulse)
- core_result_i  in  DATA_WIDTH  core output block
- out_full_i  in  1  output FIFO full flag
- out_push_o  out  1  output FIFO push
- out_data_o  out  DATA_WIDTH  output FIFO write data
- busy_o  out  1  high in any state other than IDLE
- block_cnt_o  out  CNT_WIDTH  completed-block count
- timeout_o  out  1  sticky watchdog error (tied 0 without the macro)

Behaviour:
- Reset (rst=1 at clk edge, any state incl. mid-block):
  - State goes to IDLE.
  - All outputs 0; block register, result register and block_cnt_o cleared.
  - Any in-flight block is dropped.
- States and transitions:
  - IDLE -> POP when enable_i=1 and in_empty_i=0.
  - POP: in_pop_o=1 for exactly one cycle -> LOAD.
  - LOAD: register in_data_i into the block register -> START.
  - START: core_start_o=1 for one cycle -> RUN.
  - RUN: wait for core_done_i; on done, register core_result_i -> PUSH.
  - PUSH: out_push_o = ~out_full_i. The state is held while out_full_i=1, with out_data_o stable.
  - On push (out_full_i=0): block_cnt_o increments. Go to POP if enable_i=1 and in_empty_i=0, else IDLE.
- Back-to-back blocks with no stall: one block every 4 cycles plus core latency.
- Signal rules:
  - core_done_i is ignored outside RUN.
  - in_empty_i is sampled only in IDLE and at PUSH exit.
  - enable_i deasserted mid-block: the current block completes; no new pop.
- Outputs:
  - out_data_o is driven from the result register (0 after reset).
  - core_block_o is driven from the block register.
- block_cnt_o wraps modulo 2^CNT_WIDTH.
- Never: pop while out of IDLE/PUSH exit, push twice per block, or start twice per block.

Optional Feature:
- Macro AES_STREAM_CTRL_TIMEOUT_EN.
- Defined:
  - Cycle counter clears on entering RUN.
  - If TIMEOUT_CYCLES cycles elapse in RUN without core_done_i: timeout_o set (sticky until rst), block dropped, state -> IDLE, block_cnt_o unchanged.
- Undefined: no counter; RUN waits indefinitely; timeout_o tied 0.

Decomposition:
- Shared package aes_pkg holds:
  - BLOCK_WIDTH constant (128).
  - State enum typedef aes_stream_state_e {IDLE, POP, LOAD, START, RUN, PUSH}.
- Flat module; no sub-module. The watchdog is a small in-module counter under the macro.

Test Plan:
- Bench uses a stub core returning ~block after 10 cycles.
- Single block: rst, push 00112233445566778899aabbccddeeff, enable_i=1.
  - Expect one in_pop_o, core_start_o 2 cycles later.
  - Expect out_push_o with ffeeddccbbaa99887766554433221100, block_cnt_o=1, busy_o back to 0.
- Streaming: 4 blocks queued.
  - Expect exactly 4 pops/starts/pushes in order, block_cnt_o=4.
  - Expect PUSH->POP chaining with no IDLE cycle between blocks.
- Output backpressure: out_full_i=1 for 20 cycles at PUSH.
  - out_push_o=0 and out_data_o stable throughout.
  - Single push on release; no extra pop meanwhile.
- Disable/empty: enable_i=0 with FIFO non-empty -> no pop for 50 cycles.
  - enable_i dropped in RUN -> block completes, then IDLE.
  - Spurious core_done_i in IDLE is ignored.
- Reset mid-RUN: assert rst in RUN.
  - Next cycle all outputs 0, block_cnt_o=0.
  - Late core_done_i is ignored; the next block proceeds normally.
- Timeout (macro defined): stub never returns done.
  - timeout_o=1 exactly TIMEOUT_CYCLES=64 cycles after entering RUN, then IDLE, block_cnt_o unchanged.
  - Without the macro, timeout_o stays 0.
